// File: rtl/eth_udp_framer.sv
// eth_udp_framer
//   Builds one Ethernet/IPv4/UDP frame per payload burst in an external byte-wide
//   frame buffer. It computes the IPv4 header checksum and writes the 42 header
//   bytes. It then streams PAYLOAD_LEN payload bytes from the input into the
//   buffer and hands the finished frame to a transmitter through tx_start/tx_busy.
//
//   Optional feature (compile-time macro ETH_IP_IDENT_EN):
//     defined   - IPv4 identification increments after every frame handed off
//     undefined - IPv4 identification stays 0x0000 for every frame
//
//   Ports:
//     clk           in   system clock
//     rst           in   synchronous active-high reset
//     s_data[7:0]   in   payload byte
//     s_valid       in   payload byte offered
//     s_ready       out  payload byte accepted when s_valid && s_ready
//     bram_wr_en    out  frame buffer write enable
//     bram_wr_addr  out  frame buffer byte address (byte 0 at address 0)
//     bram_wr_data  out  frame buffer write data
//     tx_start      out  frame ready, request to transmitter
//     tx_busy       in   transmitter active
//     busy          out  framer not idle
module eth_udp_framer #(
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC     = 48'h020000000001,
  parameter logic [31:0] SRC_IP      = 32'hC0A8010A,
  parameter logic [31:0] DST_IP      = 32'hC0A801FF,
  parameter logic [15:0] SRC_PORT    = 16'd1234,
  parameter logic [15:0] DST_PORT    = 16'd1234,
  parameter int          PAYLOAD_LEN = 78
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       bram_wr_en,
  output logic [9:0] bram_wr_addr,
  output logic [7:0] bram_wr_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy
);

  localparam logic [15:0] IP_TOTAL_LEN = 16'(28 + PAYLOAD_LEN);
  localparam logic [15:0] UDP_LEN      = 16'(8 + PAYLOAD_LEN);
  localparam logic [9:0]  CSUM_LAST    = 10'd9;
  localparam logic [9:0]  HDR_LAST     = 10'd41;
  localparam logic [9:0]  PAY_BASE     = 10'd42;
  localparam logic [9:0]  PAY_LAST     = 10'(PAYLOAD_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    CSUM,
    HDR,
    PAYLOAD,
    START,
    DONE
  } state_t;

  state_t       r_state, w_state_next;
  logic [9:0]   r_cnt, w_cnt_next;
  logic [16:0]  r_acc, w_acc_next;
  logic [15:0]  r_ident, w_ident_next;
  logic         r_wr_en, w_wr_en_next;
  logic [9:0]   r_wr_addr, w_wr_addr_next;
  logic [7:0]   r_wr_data, w_wr_data_next;

  logic [15:0]  w_word;
  logic [16:0]  w_sum;
  logic [15:0]  w_csum;
  logic [335:0] w_hdr_vec;
  logic [5:0]   w_hdr_rev;
  logic [8:0]   w_hdr_bit;
  logic [7:0]   w_hdr_byte;
  logic         w_accept;

  // Reset gates the handshake and request outputs combinationally so that a
  // frame is abandoned in the very cycle rst is raised.
  assign s_ready    = (r_state == PAYLOAD) && !rst;
  assign tx_start   = (r_state == START) && !rst;
  assign busy       = (r_state != IDLE) && !rst;
  assign bram_wr_en = r_wr_en && !rst;
  assign bram_wr_addr = r_wr_addr;
  assign bram_wr_data = r_wr_data;

  assign w_accept = s_valid && s_ready;

  // IPv4 header word fed to the checksum adder; the counter selects one word
  // per CSUM cycle, with the checksum field itself taken as zero.
  always_comb begin
    w_word = 16'h0000;
    case (r_cnt)
      10'd0:   w_word = 16'h4500;
      10'd1:   w_word = IP_TOTAL_LEN;
      10'd2:   w_word = r_ident;
      10'd3:   w_word = 16'h4000;
      10'd4:   w_word = 16'h4011;
      10'd5:   w_word = 16'h0000;
      10'd6:   w_word = SRC_IP[31:16];
      10'd7:   w_word = SRC_IP[15:0];
      10'd8:   w_word = DST_IP[31:16];
      10'd9:   w_word = DST_IP[15:0];
      default: w_word = 16'h0000;
    endcase
  end

  // One's-complement running sum: the carry out of each addition is folded
  // straight back in, so bit 16 of the stored accumulator never stays set.
  assign w_sum  = {1'b0, r_acc[15:0]} + {1'b0, w_word} + {16'b0, r_acc[16]};
  assign w_csum = ~r_acc[15:0];

  // The whole 42-byte header as one big-endian vector; byte i sits at
  // bit offset (41 - i) * 8 counting from the LSB.
  assign w_hdr_vec = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, IP_TOTAL_LEN,
                      r_ident, 16'h4000, 8'h40, 8'h11, w_csum, SRC_IP, DST_IP,
                      SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};
  assign w_hdr_rev  = 6'd41 - r_cnt[5:0];
  assign w_hdr_bit  = {w_hdr_rev, 3'b000};
  assign w_hdr_byte = w_hdr_vec[w_hdr_bit +: 8];

  // Next-state and next-register logic. Buffer writes are registered, so a
  // byte chosen in one cycle appears on the write port in the following one.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_acc_next     = r_acc;
    w_ident_next   = r_ident;
    w_wr_en_next   = 1'b0;
    w_wr_addr_next = r_wr_addr;
    w_wr_data_next = r_wr_data;

    case (r_state)
      IDLE: begin
        w_cnt_next = 10'd0;
        w_acc_next = 17'd0;
        if (s_valid && !tx_busy) begin
          w_state_next = CSUM;
        end
      end

      CSUM: begin
        w_acc_next = {1'b0, w_sum[15:0]} + {16'b0, w_sum[16]};
        w_cnt_next = r_cnt + 10'd1;
        if (r_cnt == CSUM_LAST) begin
          w_cnt_next   = 10'd0;
          w_state_next = HDR;
        end
      end

      HDR: begin
        w_wr_en_next   = 1'b1;
        w_wr_addr_next = r_cnt;
        w_wr_data_next = w_hdr_byte;
        w_cnt_next     = r_cnt + 10'd1;
        if (r_cnt == HDR_LAST) begin
          w_cnt_next   = 10'd0;
          w_state_next = PAYLOAD;
        end
      end

      PAYLOAD: begin
        if (w_accept) begin
          w_wr_en_next   = 1'b1;
          w_wr_addr_next = PAY_BASE + r_cnt;
          w_wr_data_next = s_data;
          w_cnt_next     = r_cnt + 10'd1;
          if (r_cnt == PAY_LAST) begin
            w_cnt_next   = 10'd0;
            w_state_next = START;
          end
        end
      end

      START: begin
        if (tx_busy) begin
          w_state_next = DONE;
`ifdef ETH_IP_IDENT_EN
          w_ident_next = r_ident + 16'd1;
`endif
        end
      end

      DONE: begin
        if (!tx_busy) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 10'd0;
      r_acc     <= 17'd0;
      r_ident   <= 16'h0000;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 10'd0;
      r_wr_data <= 8'h00;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_acc     <= w_acc_next;
      r_ident   <= w_ident_next;
      r_wr_en   <= w_wr_en_next;
      r_wr_addr <= w_wr_addr_next;
      r_wr_data <= w_wr_data_next;
    end
  end

endmodule

// File: tb/tb_eth_udp_framer.sv
// tb_eth_udp_framer
//   Self-checking bench for eth_udp_framer with default parameters. A frame
//   model built from the header field layout is compared against a shadow copy
//   of the frame buffer. Payloads are counting or random, and the s_valid
//   patterns are steady, toggling or random. Transmitter handshake, reset
//   mid-frame and ident behaviour (macro ETH_IP_IDENT_EN) are exercised too.
module tb_eth_udp_framer;

  localparam logic [47:0] DST_MAC  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC_MAC  = 48'h020000000001;
  localparam logic [31:0] SRC_IP   = 32'hC0A8010A;
  localparam logic [31:0] DST_IP   = 32'hC0A801FF;
  localparam logic [15:0] SRC_PORT = 16'd1234;
  localparam logic [15:0] DST_PORT = 16'd1234;
  localparam int PL          = 78;
  localparam int FRAME_BYTES = 42 + PL;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       bram_wr_en;
  logic [9:0] bram_wr_addr;
  logic [7:0] bram_wr_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [1024];
  int         wrAddrs[$];
  int         wrWhileBusy;
  int         txStartTicks;
  logic [7:0] pay [PL];
  logic [7:0] expFrame [FRAME_BYTES];
  logic [15:0] modelIdent;
  logic [15:0] expIdentField;
  logic [15:0] expCsumField;
  bit          completed;

  eth_udp_framer dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .bram_wr_en   (bram_wr_en),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge and log what the DUT shows there.
  task automatic tick();
    @(negedge clk);
    if (bram_wr_en === 1'b1) begin
      mem[bram_wr_addr] = bram_wr_data;
      wrAddrs.push_back(int'(bram_wr_addr));
      if (tx_busy) wrWhileBusy++;
    end
    if (tx_start === 1'b1) txStartTicks++;
  endtask

  // Expected frame from the field layout; checksum by summing all header
  // words and folding the carries at the end.
  task automatic buildFrame(input logic [15:0] ident);
    int unsigned sum;
    logic [15:0] csum;
    logic [15:0] ipLen;
    logic [15:0] udpLen;
    ipLen  = 16'(28 + PL);
    udpLen = 16'(8 + PL);
    for (int i = 0; i < 6; i++) begin
      expFrame[i]     = 8'(DST_MAC >> (8 * (5 - i)));
      expFrame[6 + i] = 8'(SRC_MAC >> (8 * (5 - i)));
    end
    expFrame[12] = 8'h08; expFrame[13] = 8'h00;
    expFrame[14] = 8'h45; expFrame[15] = 8'h00;
    expFrame[16] = ipLen[15:8]; expFrame[17] = ipLen[7:0];
    expFrame[18] = ident[15:8]; expFrame[19] = ident[7:0];
    expFrame[20] = 8'h40; expFrame[21] = 8'h00;
    expFrame[22] = 8'h40; expFrame[23] = 8'h11;
    expFrame[24] = 8'h00; expFrame[25] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      expFrame[26 + i] = 8'(SRC_IP >> (8 * (3 - i)));
      expFrame[30 + i] = 8'(DST_IP >> (8 * (3 - i)));
    end
    expFrame[34] = SRC_PORT[15:8]; expFrame[35] = SRC_PORT[7:0];
    expFrame[36] = DST_PORT[15:8]; expFrame[37] = DST_PORT[7:0];
    expFrame[38] = udpLen[15:8];   expFrame[39] = udpLen[7:0];
    expFrame[40] = 8'h00; expFrame[41] = 8'h00;
    sum = 0;
    for (int i = 14; i < 34; i += 2) sum += {16'h0, expFrame[i], expFrame[i + 1]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    csum = ~sum[15:0];
    expFrame[24] = csum[15:8]; expFrame[25] = csum[7:0];
    for (int k = 0; k < PL; k++) expFrame[42 + k] = pay[k];
  endtask

  // Drive one frame. mode 0: s_valid steady, 1: toggling, 2: random.
  // rstAt >= 0 pulses reset while that payload byte is on offer.
  task automatic applyStimulus(input int mode, input int rstAt, output bit done);
    int  k;
    int  budget;
    bit  lastReady;
    int  wrBefore;
    done = 1'b0;
    wrAddrs.delete();
    wrWhileBusy  = 0;
    txStartTicks = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'hxx;
    k = 0; budget = 0; lastReady = 1'b0;
    s_valid = 1'b1; s_data = pay[0]; tx_busy = 1'b0;
    while (k < PL && budget < 3000) begin
      tick();
      budget++;
      if (s_valid && lastReady) k++;
      if (rstAt >= 0 && k == rstAt) begin
        rst = 1'b1;
        s_valid = 1'b1; s_data = pay[k];
        tick();
        checkOutput("rst_wr_en", bram_wr_en, 1'b0);
        checkOutput("rst_ready", s_ready, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        rst = 1'b0; s_valid = 1'b0;
        wrBefore = wrAddrs.size();
        for (int i = 0; i < 200; i++) tick();
        checkOutput("rst_no_tx_start", txStartTicks, 0);
        checkOutput("rst_no_writes", wrAddrs.size(), wrBefore);
        return;
      end
      lastReady = s_ready;
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = lastReady ? !s_valid : 1'b1;
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      if (k < PL) s_data = pay[k];
      else begin s_valid = 1'b1; s_data = 8'hEE; end
    end
    checkOutput("payload_accepted", k, PL);
    if (k != PL) return;
    checkOutput("ready_drop", s_ready, 1'b0);
    checkOutput("writes_at_tx_start", wrAddrs.size(), FRAME_BYTES);
    checkOutput("tx_start_rise", tx_start, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    tx_busy = 1'b1;
    tick();
    checkOutput("tx_start_cycles", txStartTicks, 6);
    checkOutput("tx_start_drop", tx_start, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("done_hold_busy", busy, 1'b1);
    checkOutput("no_write_tx_busy", wrWhileBusy, 0);
    tx_busy = 1'b0; s_valid = 1'b0;
    tick(); tick();
    checkOutput("back_idle", busy, 1'b0);
    done = 1'b1;
  endtask

  // Compare the logged buffer against the model and spot header fields.
  task automatic checkFrame(input logic [15:0] ident, input logic [15:0] identField,
                            input logic [15:0] csumField);
    int gaps;
    int diffs;
    int n;
    buildFrame(ident);
    checkOutput("write_count", wrAddrs.size(), FRAME_BYTES);
    n = (wrAddrs.size() < FRAME_BYTES) ? wrAddrs.size() : FRAME_BYTES;
    gaps = 0;
    for (int i = 0; i < n; i++) if (wrAddrs[i] != i) gaps++;
    checkOutput("addr_sequence", gaps, 0);
    diffs = 0;
    for (int i = 0; i < FRAME_BYTES; i++) if (mem[i] !== expFrame[i]) diffs++;
    checkOutput("frame_bytes", diffs, 0);
    checkOutput("ip_total_len", {mem[16], mem[17]}, 16'h006A);
    checkOutput("udp_len", {mem[38], mem[39]}, 16'h0056);
    checkOutput("ident_field", {mem[18], mem[19]}, identField);
    checkOutput("csum_field", {mem[24], mem[25]}, csumField);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; tx_busy = 1'b0;
    wrWhileBusy = 0; txStartTicks = 0;
    modelIdent = 16'h0000;
    tick(); tick(); tick();
    checkOutput("reset_ready", s_ready, 1'b0);
    checkOutput("reset_wr_en", bram_wr_en, 1'b0);
    checkOutput("reset_wr_addr", bram_wr_addr, 10'd0);
    checkOutput("reset_wr_data", bram_wr_data, 8'h00);
    checkOutput("reset_tx_start", tx_start, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("idle_busy", busy, 1'b0);

    $display("[TB] idle holds while transmitter busy");
    s_valid = 1'b1; tx_busy = 1'b1;
    wrAddrs.delete();
    for (int i = 0; i < 5; i++) tick();
    checkOutput("idle_blocked_busy", busy, 1'b0);
    checkOutput("idle_blocked_writes", wrAddrs.size(), 0);

    $display("[TB] frame 1: counting payload, steady valid");
    for (int i = 0; i < PL; i++) pay[i] = 8'(i);
    applyStimulus(0, -1, completed);
    checkFrame(modelIdent, 16'h0000, 16'hB629);
`ifdef ETH_IP_IDENT_EN
    if (completed) modelIdent = modelIdent + 16'd1;
    expIdentField = 16'h0001; expCsumField = 16'hB628;
`else
    expIdentField = 16'h0000; expCsumField = 16'hB629;
`endif

    $display("[TB] frame 2: random payload, toggling valid");
    for (int i = 0; i < PL; i++) pay[i] = 8'($urandom);
    applyStimulus(1, -1, completed);
    checkFrame(modelIdent, expIdentField, expCsumField);
`ifdef ETH_IP_IDENT_EN
    if (completed) modelIdent = modelIdent + 16'd1;
`endif

    $display("[TB] frame 3: reset at payload byte 10");
    for (int i = 0; i < PL; i++) pay[i] = 8'($urandom);
    applyStimulus(2, 10, completed);
    modelIdent = 16'h0000;

    $display("[TB] frame 4: fresh frame after reset, random valid");
    for (int i = 0; i < PL; i++) pay[i] = 8'($urandom);
    applyStimulus(2, -1, completed);
    checkFrame(modelIdent, 16'h0000, 16'hB629);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_udp_framer.md
ETH_UDP_FRAMER -- requirements
Module: eth_udp_framer

Interface
REQ-001 SHALL have parameter DST_MAC, default 48'hFFFFFFFFFFFF, destination MAC.
REQ-002 SHALL have parameter SRC_MAC, default 48'h020000000001, source MAC.
REQ-003 SHALL have parameters SRC_IP/DST_IP, defaults 32'hC0A8010A/32'hC0A801FF, IPv4 addresses.
REQ-004 SHALL have parameters SRC_PORT/DST_PORT, defaults 16'd1234/16'd1234, UDP ports.
REQ-005 SHALL have parameter PAYLOAD_LEN, default 78, payload bytes per frame (1..982).
REQ-006 SHALL have ports: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: s_data  in  8  payload byte; s_valid  in  1  byte offered; s_ready  out  1  byte accepted when s_valid&&s_ready.
REQ-008 SHALL have ports: bram_wr_en  out  1; bram_wr_addr  out  10; bram_wr_data  out  8 -- frame buffer write port, byte 0 at address 0.
REQ-009 SHALL have ports: tx_start  out  1  request to transmitter; tx_busy  in  1  transmitter active.
REQ-010 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, CSUM, HDR, PAYLOAD, START, DONE.
REQ-012 IDLE->CSUM SHALL occur when s_valid==1 and tx_busy==0; s_ready=0 in IDLE.
REQ-013 CSUM SHALL sum the 10 IPv4 header 16-bit words (checksum word = 0), one word per cycle, 17-bit accumulator with end-around carry folded each cycle; final checksum = ~sum[15:0]; then ->HDR.
REQ-014 HDR SHALL write bytes 0..41, one per cycle, addr = byte index: 0-5 DST_MAC, 6-11 SRC_MAC, 12-13 0x0800, 14 0x45, 15 0x00, 16-17 28+PAYLOAD_LEN, 18-19 ident, 20-21 0x4000, 22 0x40, 23 0x11, 24-25 checksum, 26-29 SRC_IP, 30-33 DST_IP, 34-35 SRC_PORT, 36-37 DST_PORT, 38-39 8+PAYLOAD_LEN, 40-41 0x0000; all multi-byte fields big-endian.
REQ-015 PAYLOAD SHALL assert s_ready; each accepted byte SHALL be written at addr 42+k in the cycle after acceptance (k = 0..PAYLOAD_LEN-1); s_valid low SHALL stall with bram_wr_en=0.
REQ-016 After byte PAYLOAD_LEN-1 accepted, s_ready SHALL drop the next cycle (no extra acceptance) and state ->START.
REQ-017 START SHALL hold tx_start=1 until tx_busy==1 is sampled, then ->DONE with tx_start=0 next cycle.
REQ-018 DONE SHALL wait for tx_busy==0, then ->IDLE; buffer SHALL never be written while tx_busy==1.
REQ-019 bram_wr_en SHALL be high only for the 42 HDR writes and PAYLOAD_LEN payload writes per frame.
REQ-020 ident SHALL be 16 bits, wrap 0xFFFF->0x0000.

Reset
REQ-021 rst SHALL force state IDLE, s_ready=0, bram_wr_en=0, bram_wr_addr=0, bram_wr_data=0, tx_start=0, busy=0, ident=0, accumulator=0.
REQ-022 rst mid-frame SHALL abandon the frame in the same cycle; no further writes, no tx_start; partial buffer contents undefined.

Configuration
REQ-023 Macro ETH_IP_IDENT_EN defined: ident SHALL increment by 1 on each START->DONE transition.
REQ-024 Macro ETH_IP_IDENT_EN undefined: ident SHALL be constant 0x0000 and checksum identical for every frame.

Verification
REQ-025 Defaults, ident=0, 78 payload bytes 0x00..0x4D, tx_busy=0 -> bytes 16-17=0x006A, 24-25=0xB629, 38-39=0x0056, byte 42+k=k, tx_start rises after 120 writes.
REQ-026 Second frame with ETH_IP_IDENT_EN -> bytes 18-19=0x0001, 24-25=0xB628; without macro -> 0x0000/0xB629.
REQ-027 s_valid toggled 1/0 each cycle during payload -> 78 writes only, addresses 42..119 contiguous, no gaps or duplicates.
REQ-028 tx_busy held 0 for 5 cycles after tx_start then 1 -> tx_start high 6 cycles, drops next cycle; s_valid=1 while tx_busy=1 -> stays in DONE, no writes.
REQ-029 rst pulsed at payload byte 10 -> next cycle bram_wr_en=0, s_ready=0, tx_start never asserted; fresh frame afterwards starts at addr 0 with ident=0.
